multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Multi-cycle sequencer for the MIPS-subset datapath (R-type, addi, lw, sw, beq, bne, bgtz).
//  Replaces per-instruction combinational decode with a Moore FSM that time-shares one ALU and one memory port
//  across FETCH/DECODE/EXEC/MEM/WB steps. It handles memory handshakes (mem_ready), a wait-timeout, and illegal-opcode traps.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles a memory state waits for mem_ready before TRAP (>=1)
//  CNT_W        5   width of wait counter; must hold MEM_TIMEOUT
// PORTS
//  clk        in   1  rising-edge clock (single domain)
//  rst_n      in   1  synchronous, active-low reset
//  Opcode     in   6  IR[31:26], valid from DECODE onward (IR held while IRWr=0)
//  Zero       in   1  ALU result == 0
//  AluResMsb  in   1  ALU result bit 31
//  mem_ready  in   1  memory completes current MemRd/MemWr this cycle
//  PCWr       out  1  load PC; PCSrc selects source
//  PCSrc      out  1  0: ALU result (PC+4), 1: ALUOut register (branch target)
//  IorD       out  1  memory address: 0 PC, 1 ALUOut
//  MemRd      out  1  memory read request, held until mem_ready
//  MemWr      out  1  memory write request, held until mem_ready
//  IRWr       out  1  load instruction register
//  RegDst     out  1  write-register select: 1 rd, 0 rt
//  RegWr      out  1  register-file write enable
//  MemtoReg   out  1  write-back data: 1 MDR, 0 ALUOut
//  ExtOp      out  1  1 sign-extend immediate
//  AluSrcA    out  1  0 PC, 1 rs
//  AluSrcB    out  2  00 rt, 01 const 4, 10 ext imm, 11 ext imm<<2
//  AluOp      out  2  00 add, 01 sub, 10 funct-decode
//  retire     out  1  one-cycle pulse in final state of each instruction
//  trap       out  1  sticky: illegal opcode or memory timeout
//  trap_cause out  1  0 illegal opcode, 1 memory timeout (valid while trap=1)
//  state      out  4  current state encoding (debug)
// BEHAVIOUR
//  - Reset: rst_n=0 at a clk edge -> state=IDLE, wait_cnt=0, trap=0, trap_cause=0; IDLE drives all outputs 0.
//  - Encoding: IDLE=0 FETCH=1 DECODE=2 EXEC_R=3 EXEC_I=4 ADDR=5 MEM_RD=6 MEM_WR=7 WB_R=8 WB_I=9 WB_LD=10 BRANCH=11 TRAP=15.
//  - Outputs are Moore (decoded from state). Exception: PCWr in BRANCH is combinational on Zero/AluResMsb.
//  - Unlisted outputs are 0 in each state below.
//  - IDLE: -> FETCH next cycle.
//  - FETCH: MemRd=1, IorD=0, AluSrcA=0, AluSrcB=01, AluOp=00.
//      On mem_ready: IRWr=1, PCWr=1, PCSrc=0, then -> DECODE. Otherwise stay and increment wait_cnt.
//  - DECODE: AluSrcA=0, AluSrcB=11, ExtOp=1, AluOp=00 (branch target -> ALUOut). Next state by Opcode:
//      000000->EXEC_R; 001000->EXEC_I; 100011/101011->ADDR; 000100/000101/000111->BRANCH; other->TRAP (cause 0).
//  - EXEC_R: AluSrcA=1, AluSrcB=00, AluOp=10 -> WB_R.  WB_R: RegDst=1, RegWr=1, retire=1 -> FETCH.
//  - EXEC_I: AluSrcA=1, AluSrcB=10, ExtOp=1, AluOp=00 -> WB_I.  WB_I: RegDst=0, RegWr=1, retire=1 -> FETCH.
//  - ADDR: same ALU controls as EXEC_I. Opcode 100011 -> MEM_RD; 101011 -> MEM_WR.
//  - MEM_RD: MemRd=1, IorD=1; on mem_ready -> WB_LD.  WB_LD: RegWr=1, MemtoReg=1, RegDst=0, retire=1 -> FETCH.
//  - MEM_WR: MemWr=1, IorD=1; on mem_ready: retire=1 -> FETCH.
//  - BRANCH: AluSrcA=1, AluSrcB=00, AluOp=01 (rs-rt), PCSrc=1, retire=1 -> FETCH.
//      PCWr = (beq&Zero) | (bne&~Zero) | (bgtz&~Zero&~AluResMsb).
//  - Wait counter: cleared on every state change. Increments each cycle in FETCH/MEM_RD/MEM_WR without mem_ready.
//      If wait_cnt==MEM_TIMEOUT-1 and mem_ready=0 -> TRAP (cause 1); request drops the next cycle.
//      If mem_ready arrives in that same cycle, it wins: normal transition, no trap.
//  - TRAP: all control outputs 0, trap=1. Held until reset (sticky); trap_cause frozen.
//  - mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
//  - Reset mid-operation (any state, including a pending MemRd/MemWr) aborts the instruction:
//      next cycle is IDLE, no retire, no PCWr/RegWr/MemWr.
//  - Minimum latency with mem_ready tied 1: R/addi/lw 4/4/5 cycles from FETCH entry; sw 4; branch 3.
// TESTING
//  - Reset: hold rst_n=0 for 2 clk -> every output 0, state=0; release -> state 1 (FETCH) with MemRd=1 one cycle later.
//  - add (Opcode 000000), mem_ready=1: states 1,2,3,8. WB_R shows RegWr=1, RegDst=1, retire=1, then back to 1.
//  - lw (100011), mem_ready low for 3 cycles in MEM_RD: MemRd stays 1 and IorD stays 1 for 4 cycles.
//      Then WB_LD shows MemtoReg=1, RegWr=1; retire pulses exactly once.
//  - Branches (000100 Zero=1; 000101 Zero=1; 000111 Zero=0 AluResMsb=0): PCWr=1, 0, 1 respectively in BRANCH, PCSrc=1.
//  - Opcode 111111 in DECODE -> state 15, trap=1, trap_cause=0. Holds with all controls 0 for 20 cycles until rst_n=0.
//  - sw with mem_ready=0, MEM_TIMEOUT=16: MemWr high 16 cycles, then TRAP with cause 1.
//      Repeat with mem_ready=1 on the 16th cycle -> retire=1, no trap.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the MIPS-subset datapath: one ALU and one memory port shared
// across FETCH/DECODE/EXEC/MEM/WB steps, with memory wait timeout and illegal-opcode traps.
module multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Opcode,
    input  logic       Zero,
    input  logic       AluResMsb,
    input  logic       mem_ready,
    output logic       PCWr,
    output logic       PCSrc,
    output logic       IorD,
    output logic       MemRd,
    output logic       MemWr,
    output logic       IRWr,
    output logic       RegDst,
    output logic       RegWr,
    output logic       MemtoReg,
    output logic       ExtOp,
    output logic       AluSrcA,
    output logic [1:0] AluSrcB,
    output logic [1:0] AluOp,
    output logic       retire,
    output logic       trap,
    output logic       trap_cause,
    output logic [3:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        EXEC_R = 4'd3,
        EXEC_I = 4'd4,
        ADDR   = 4'd5,
        MEM_RD = 4'd6,
        MEM_WR = 4'd7,
        WB_R   = 4'd8,
        WB_I   = 4'd9,
        WB_LD  = 4'd10,
        BRANCH = 4'd11,
        TRAP   = 4'd15
    } state_t;

    state_t           cur_state;
    state_t           next_state;
    logic [CNT_W-1:0] wait_cnt;
    logic             mem_state;
    logic             timeout;

    assign state = cur_state;

    // A memory step times out only on its last allowed cycle; a same-cycle mem_ready wins.
    always_comb begin
        mem_state = (cur_state == FETCH) || (cur_state == MEM_RD) || (cur_state == MEM_WR);
        timeout   = mem_state && !mem_ready && (wait_cnt == WAIT_LAST);
    end

    always_comb begin
        next_state = cur_state;
        case (cur_state)
            IDLE:   next_state = FETCH;
            FETCH: begin
                if (mem_ready)    next_state = DECODE;
                else if (timeout) next_state = TRAP;
            end
            DECODE: begin
                case (Opcode)
                    OP_RTYPE:                 next_state = EXEC_R;
                    OP_ADDI:                  next_state = EXEC_I;
                    OP_LW, OP_SW:             next_state = ADDR;
                    OP_BEQ, OP_BNE, OP_BGTZ:  next_state = BRANCH;
                    default:                  next_state = TRAP;
                endcase
            end
            EXEC_R: next_state = WB_R;
            EXEC_I: next_state = WB_I;
            ADDR:   next_state = (Opcode == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD: begin
                if (mem_ready)    next_state = WB_LD;
                else if (timeout) next_state = TRAP;
            end
            MEM_WR: begin
                if (mem_ready)    next_state = FETCH;
                else if (timeout) next_state = TRAP;
            end
            WB_R, WB_I, WB_LD, BRANCH: next_state = FETCH;
            TRAP:   next_state = TRAP;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_state  <= IDLE;
            wait_cnt   <= '0;
            trap       <= 1'b0;
            trap_cause <= 1'b0;
        end else begin
            cur_state <= next_state;
            if (next_state != cur_state) begin
                wait_cnt <= '0;
            end else if (mem_state && !mem_ready) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            // Cause is captured once on trap entry and frozen until reset.
            if ((next_state == TRAP) && (cur_state != TRAP)) begin
                trap       <= 1'b1;
                trap_cause <= timeout;
            end
        end
    end

    // Control decode from the current step; FETCH/MEM_WR/BRANCH also look at live inputs.
    always_comb begin
        PCWr     = 1'b0;
        PCSrc    = 1'b0;
        IorD     = 1'b0;
        MemRd    = 1'b0;
        MemWr    = 1'b0;
        IRWr     = 1'b0;
        RegDst   = 1'b0;
        RegWr    = 1'b0;
        MemtoReg = 1'b0;
        ExtOp    = 1'b0;
        AluSrcA  = 1'b0;
        AluSrcB  = 2'b00;
        AluOp    = 2'b00;
        retire   = 1'b0;
        case (cur_state)
            FETCH: begin
                MemRd   = 1'b1;
                AluSrcB = 2'b01;
                if (mem_ready) begin
                    IRWr = 1'b1;
                    PCWr = 1'b1;
                end
            end
            DECODE: begin
                AluSrcB = 2'b11;
                ExtOp   = 1'b1;
            end
            EXEC_R: begin
                AluSrcA = 1'b1;
                AluOp   = 2'b10;
            end
            EXEC_I, ADDR: begin
                AluSrcA = 1'b1;
                AluSrcB = 2'b10;
                ExtOp   = 1'b1;
            end
            MEM_RD: begin
                MemRd = 1'b1;
                IorD  = 1'b1;
            end
            MEM_WR: begin
                MemWr  = 1'b1;
                IorD   = 1'b1;
                retire = mem_ready;
            end
            WB_R: begin
                RegDst = 1'b1;
                RegWr  = 1'b1;
                retire = 1'b1;
            end
            WB_I: begin
                RegWr  = 1'b1;
                retire = 1'b1;
            end
            WB_LD: begin
                RegWr    = 1'b1;
                MemtoReg = 1'b1;
                retire   = 1'b1;
            end
            BRANCH: begin
                AluSrcA = 1'b1;
                AluOp   = 2'b01;
                PCSrc   = 1'b1;
                retire  = 1'b1;
                PCWr    = ((Opcode == OP_BEQ)  && Zero) ||
                          ((Opcode == OP_BNE)  && !Zero) ||
                          ((Opcode == OP_BGTZ) && !Zero && !AluResMsb);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-plan reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with resets.
module tb_multicycle_control;

    localparam int TO = 16;

    localparam int S_IDLE = 0,  S_FETCH = 1, S_DECODE = 2, S_EXEC_R = 3, S_EXEC_I = 4;
    localparam int S_ADDR = 5,  S_MEM_RD = 6, S_MEM_WR = 7, S_WB_R = 8, S_WB_I = 9;
    localparam int S_WB_LD = 10, S_BRANCH = 11, S_TRAP = 15;

    localparam logic [5:0] OP_R = 6'h00, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_BGTZ = 6'h07;

    // Bit positions inside the packed control snapshot
    localparam int B_RET = 0, B_SRCA = 5, B_EXT = 6, B_M2R = 7, B_REGWR = 8, B_REGDST = 9;
    localparam int B_IRWR = 10, B_MEMWR = 11, B_MEMRD = 12, B_IORD = 13, B_PCSRC = 14, B_PCWR = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] Opcode = 6'h00;
    logic       Zero = 1'b0;
    logic       AluResMsb = 1'b0;
    logic       mem_ready = 1'b0;
    logic       PCWr, PCSrc, IorD, MemRd, MemWr, IRWr, RegDst, RegWr, MemtoReg, ExtOp, AluSrcA;
    logic [1:0] AluSrcB, AluOp;
    logic       retire, trap, trap_cause;
    logic [3:0] state;

    multicycle_control #(.MEM_TIMEOUT(TO), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Zero(Zero), .AluResMsb(AluResMsb),
        .mem_ready(mem_ready), .PCWr(PCWr), .PCSrc(PCSrc), .IorD(IorD), .MemRd(MemRd),
        .MemWr(MemWr), .IRWr(IRWr), .RegDst(RegDst), .RegWr(RegWr), .MemtoReg(MemtoReg),
        .ExtOp(ExtOp), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .AluOp(AluOp), .retire(retire),
        .trap(trap), .trap_cause(trap_cause), .state(state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: current step plus the remaining steps of the decoded instruction
    int  m_state = 0;
    int  m_wait = 0;
    bit  m_trap = 0;
    bit  m_cause = 0;
    bit  m_known = 0;
    int  m_plan[$];

    logic [5:0]  cur_op = 6'h00;
    logic [3:0]  obs_state;
    logic [15:0] obs_ctrl;
    logic [1:0]  obs_trap;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_ctrl(input int st, input logic rdy, input logic z,
                                             input logic msb, input logic [5:0] op);
        logic pcwr, pcsrc, iord, memrd, memwr, irwr, regdst, regwr, m2r, extop, srca, ret;
        logic [1:0] srcb, aluop;
        pcwr = 0; pcsrc = 0; iord = 0; memrd = 0; memwr = 0; irwr = 0; regdst = 0;
        regwr = 0; m2r = 0; extop = 0; srca = 0; ret = 0; srcb = 2'b00; aluop = 2'b00;
        case (st)
            S_FETCH:  begin memrd = 1; srcb = 2'b01; irwr = rdy; pcwr = rdy; end
            S_DECODE: begin srcb = 2'b11; extop = 1; end
            S_EXEC_R: begin srca = 1; aluop = 2'b10; end
            S_EXEC_I, S_ADDR: begin srca = 1; srcb = 2'b10; extop = 1; end
            S_MEM_RD: begin memrd = 1; iord = 1; end
            S_MEM_WR: begin memwr = 1; iord = 1; ret = rdy; end
            S_WB_R:   begin regdst = 1; regwr = 1; ret = 1; end
            S_WB_I:   begin regwr = 1; ret = 1; end
            S_WB_LD:  begin regwr = 1; m2r = 1; ret = 1; end
            S_BRANCH: begin
                srca = 1; aluop = 2'b01; pcsrc = 1; ret = 1;
                pcwr = ((op == OP_BEQ) && z) || ((op == OP_BNE) && !z) ||
                       ((op == OP_BGTZ) && !z && !msb);
            end
            default: ;
        endcase
        return {pcwr, pcsrc, iord, memrd, memwr, irwr, regdst, regwr, m2r, extop, srca,
                srcb, aluop, ret};
    endfunction

    task automatic model_next(input logic r, input logic rdy, input logic [5:0] op);
        int nxt;
        bit is_mem;
        if (!r) begin
            m_state = S_IDLE; m_wait = 0; m_trap = 0; m_cause = 0; m_known = 1;
            m_plan.delete();
            return;
        end
        if (!m_known) return;
        nxt    = m_state;
        is_mem = (m_state == S_FETCH) || (m_state == S_MEM_RD) || (m_state == S_MEM_WR);
        if (m_state == S_TRAP) begin
            nxt = S_TRAP;
        end else if (is_mem && !rdy) begin
            if (m_wait == TO - 1) begin nxt = S_TRAP; m_trap = 1; m_cause = 1; end
        end else if (m_state == S_IDLE) begin
            nxt = S_FETCH;
        end else if (m_state == S_FETCH) begin
            nxt = S_DECODE;
        end else if (m_state == S_DECODE) begin
            m_plan.delete();
            case (op)
                OP_R:    begin m_plan.push_back(S_EXEC_R); m_plan.push_back(S_WB_R); end
                OP_ADDI: begin m_plan.push_back(S_EXEC_I); m_plan.push_back(S_WB_I); end
                OP_LW:   begin m_plan.push_back(S_ADDR); m_plan.push_back(S_MEM_RD);
                               m_plan.push_back(S_WB_LD); end
                OP_SW:   begin m_plan.push_back(S_ADDR); m_plan.push_back(S_MEM_WR); end
                OP_BEQ, OP_BNE, OP_BGTZ: m_plan.push_back(S_BRANCH);
                default: ;
            endcase
            if (m_plan.size() == 0) begin nxt = S_TRAP; m_trap = 1; m_cause = 0; end
            else nxt = m_plan.pop_front();
        end else if (m_plan.size() == 0) begin
            nxt = S_FETCH;
        end else begin
            nxt = m_plan.pop_front();
        end
        if (nxt != m_state) m_wait = 0;
        else if (is_mem && !rdy) m_wait++;
        m_state = nxt;
    endtask

    // One clock: drive after negedge, compare against the model, advance the model.
    task automatic tick(input logic r, input logic rdy, input logic z, input logic msb);
        rst_n = r; mem_ready = rdy; Zero = z; AluResMsb = msb; Opcode = cur_op;
        #1;
        obs_state = state;
        obs_ctrl  = {PCWr, PCSrc, IorD, MemRd, MemWr, IRWr, RegDst, RegWr, MemtoReg, ExtOp,
                     AluSrcA, AluSrcB, AluOp, retire};
        obs_trap  = {trap, trap_cause};
        if (m_known) begin
            check("model_state", 32'(obs_state), 32'(m_state));
            check("model_ctrl", 32'(obs_ctrl), 32'(exp_ctrl(m_state, rdy, z, msb, cur_op)));
            check("model_trap", 32'(obs_trap), 32'({m_trap, m_cause}));
        end
        model_next(r, rdy, cur_op);
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [5:0] br_op [3];
    logic       br_z [3];
    logic       br_m [3];
    logic       br_pc [3];

    initial begin
        int cnt;
        int rets;
        int trap_age;
        int rdy_pct;
        logic r, rdy;

        br_op[0] = OP_BEQ;  br_z[0] = 1; br_m[0] = 0; br_pc[0] = 1;
        br_op[1] = OP_BNE;  br_z[1] = 1; br_m[1] = 0; br_pc[1] = 0;
        br_op[2] = OP_BGTZ; br_z[2] = 0; br_m[2] = 0; br_pc[2] = 1;

        @(negedge clk);
        // Reset held for two clocks, then release into FETCH
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        check("rst_state", 32'(obs_state), 32'd0);
        check("rst_ctrl", 32'(obs_ctrl), 32'd0);
        check("rst_trap", 32'(obs_trap), 32'd0);
        tick(1, 1, 0, 0);
        check("idle_state", 32'(obs_state), 32'd0);
        tick(1, 1, 0, 0);
        check("fetch_state", 32'(obs_state), 32'd1);
        check("fetch_memrd", 32'(obs_ctrl[B_MEMRD]), 32'd1);
        check("fetch_irwr", 32'(obs_ctrl[B_IRWR] & obs_ctrl[B_PCWR]), 32'd1);

        // add: 1,2,3,8 then FETCH
        cur_op = OP_R;
        tick(1, 1, 0, 0); check("add_decode", 32'(obs_state), 32'd2);
        tick(1, 1, 0, 0); check("add_exec", 32'(obs_state), 32'd3);
        tick(1, 1, 0, 0); check("add_wb", 32'(obs_state), 32'd8);
        check("add_wb_ctrl", 32'(obs_ctrl), 32'h0301);
        tick(1, 1, 0, 0); check("add_fetch", 32'(obs_state), 32'd1);

        // lw with three wait cycles in MEM_RD
        cur_op = OP_LW; cnt = 0; rets = 0;
        tick(1, 1, 0, 0); rets += int'(obs_ctrl[B_RET]);
        tick(1, 1, 0, 0); check("lw_addr", 32'(obs_state), 32'd5); rets += int'(obs_ctrl[B_RET]);
        for (int i = 0; i < 4; i++) begin
            tick(1, (i == 3), 0, 0);
            cnt  += int'(obs_ctrl[B_MEMRD] & obs_ctrl[B_IORD]);
            rets += int'(obs_ctrl[B_RET]);
        end
        check("lw_memrd_cycles", 32'(cnt), 32'd4);
        tick(1, 1, 0, 0); check("lw_wb", 32'(obs_state), 32'd10);
        check("lw_wb_ctrl", 32'(obs_ctrl[B_M2R] & obs_ctrl[B_REGWR]), 32'd1);
        rets += int'(obs_ctrl[B_RET]);
        check("lw_retire_once", 32'(rets), 32'd1);
        tick(1, 1, 0, 0); check("lw_fetch", 32'(obs_state), 32'd1);

        // beq/bne/bgtz outcomes
        for (int i = 0; i < 3; i++) begin
            cur_op = br_op[i];
            tick(1, 1, 0, 0);
            tick(1, 1, br_z[i], br_m[i]);
            check("br_state", 32'(obs_state), 32'd11);
            check("br_pcwr", 32'(obs_ctrl[B_PCWR]), 32'(br_pc[i]));
            check("br_pcsrc", 32'(obs_ctrl[B_PCSRC]), 32'd1);
            tick(1, 1, 0, 0);
        end

        // sw: ready arrives on the 16th wait cycle -> retire, no trap
        cur_op = OP_SW; cnt = 0;
        tick(1, 1, 0, 0);
        tick(1, 1, 0, 0);
        for (int i = 0; i < 15; i++) begin tick(1, 0, 0, 0); cnt += int'(obs_ctrl[B_MEMWR]); end
        tick(1, 1, 0, 0);
        check("sw_late_retire", 32'(obs_ctrl[B_RET]), 32'd1);
        check("sw_late_cycles", 32'(cnt + int'(obs_ctrl[B_MEMWR])), 32'd16);
        tick(1, 1, 0, 0);
        check("sw_late_fetch", 32'(obs_state), 32'd1);
        check("sw_late_notrap", 32'(obs_trap), 32'd0);

        // sw: never ready -> 16 MemWr cycles then TRAP cause 1
        cnt = 0;
        tick(1, 1, 0, 0);
        tick(1, 1, 0, 0);
        for (int i = 0; i < 16; i++) begin tick(1, 0, 0, 0); cnt += int'(obs_ctrl[B_MEMWR]); end
        check("sw_to_cycles", 32'(cnt), 32'd16);
        tick(1, 1, 0, 0);
        check("sw_to_state", 32'(obs_state), 32'd15);
        check("sw_to_trap", 32'(obs_trap), 32'd3);
        check("sw_to_ctrl", 32'(obs_ctrl), 32'd0);
        tick(0, 1, 0, 0);
        tick(1, 1, 0, 0);
        check("sw_to_rst", 32'(obs_state), 32'd0);
        check("sw_to_rst_trap", 32'(obs_trap), 32'd0);

        // illegal opcode -> sticky TRAP cause 0
        tick(1, 1, 0, 0);
        cur_op = 6'h3F;
        tick(1, 1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            tick(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
            check("ill_hold", 32'({obs_state, obs_ctrl, obs_trap}), 32'({4'hF, 16'h0, 2'b10}));
        end
        tick(0, 0, 0, 0);
        tick(1, 0, 0, 0);
        check("ill_rst", 32'(obs_state), 32'd0);

        // Randomized traffic including mid-instruction resets and timeouts
        trap_age = 0; rdy_pct = 90;
        for (int n = 0; n < 5000; n++) begin
            if (m_state == S_FETCH) begin
                case ($urandom_range(0, 8))
                    0: cur_op = OP_R;
                    1: cur_op = OP_ADDI;
                    2: cur_op = OP_LW;
                    3: cur_op = OP_SW;
                    4: cur_op = OP_BEQ;
                    5: cur_op = OP_BNE;
                    6: cur_op = OP_BGTZ;
                    7: cur_op = OP_LW;
                    default: cur_op = 6'($urandom_range(0, 63));
                endcase
                case ($urandom_range(0, 3))
                    0: rdy_pct = 5;
                    1: rdy_pct = 50;
                    default: rdy_pct = 90;
                endcase
            end
            trap_age = (m_state == S_TRAP) ? trap_age + 1 : 0;
            r   = !(($urandom_range(0, 249) == 0) || (trap_age > 8));
            rdy = ($urandom_range(0, 99) < rdy_pct);
            tick(r, rdy, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
